// File: rtl/tile_grid_renderer_if.sv
// ROM-side bus of the tile grid renderer: the renderer drives both ROM addresses
// and receives the background and tile ROM data ROM_LAT cycles later.
interface tile_grid_renderer_if #(
    parameter int TA_W = 8
);
    logic [18:0]     bg_addr;
    logic [TA_W-1:0] tile_addr;
    logic [11:0]     bg_data;
    logic [11:0]     tile_data;

    modport master (output bg_addr, output tile_addr, input bg_data, input tile_data);
    modport slave  (input bg_addr, input tile_addr, output bg_data, output tile_data);
endinterface

// File: rtl/tile_grid_renderer.sv
// Composites a GRID_COLS x GRID_ROWS tile grid over a background image, with
// incremental (division-free) tile addressing, frame-latched cell map and blink.
module tile_grid_renderer #(
    parameter int          GRID_COLS    = 10,
    parameter int          GRID_ROWS    = 20,
    parameter int          TILE         = 14,
    parameter int          ORIGIN_X     = 208,
    parameter int          ORIGIN_Y     = 105,
    parameter int          H_ACTIVE     = 640,
    parameter int          ROM_LAT      = 1,
    parameter int          FLASH_FRAMES = 16,
    parameter logic [11:0] FLASH_COLOR  = 12'hCCC
) (
    input  logic                           clk,
    input  logic                           clrn,
    input  logic                           pix_valid,
    input  logic [8:0]                     row_addr,
    input  logic [9:0]                     col_addr,
    input  logic [GRID_COLS*GRID_ROWS-1:0] cell_matrix,
    input  logic [GRID_COLS*GRID_ROWS-1:0] flash_mask,
    tile_grid_renderer_if.master           rom,
    output logic [11:0]                    pix_out,
    output logic                           pix_valid_out
);
    localparam int NCELL = GRID_COLS * GRID_ROWS;
    localparam int TA_W  = $clog2(TILE * TILE);
    localparam int TX_W  = $clog2(TILE);
    localparam int CX_W  = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
    localparam int CY_W  = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
    localparam int CI_W  = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int FC_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [10:0]     X0     = 11'(ORIGIN_X);
    localparam logic [10:0]     X1     = 11'(ORIGIN_X + GRID_COLS * TILE);
    localparam logic [9:0]      Y0     = 10'(ORIGIN_Y);
    localparam logic [9:0]      Y1     = 10'(ORIGIN_Y + GRID_ROWS * TILE);
    localparam logic [TX_W-1:0] T_MAX  = TX_W'(TILE - 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FLASH_FRAMES - 1);

    logic [TX_W-1:0]  r_tx, r_ty, w_tx, w_ty;
    logic [CX_W-1:0]  r_cx, w_cx;
    logic [CY_W-1:0]  r_cy, w_cy;
    logic [NCELL-1:0] r_cell_sh, r_flash_sh, w_cells, w_flashes;
    logic [FC_W-1:0]  r_fcnt;
    logic             r_fs_seen, r_phase, w_phase, w_wrap;
    logic             w_fs, w_line, w_in_cols, w_in_rows, w_in_grid;
    logic [10:0]      w_col;
    logic [9:0]       w_row;
    logic [CI_W-1:0]  w_idx;
    logic             w_cell_bit, w_lit;

    logic [18:0]      r_bg_addr;
    logic [TA_W-1:0]  r_tile_addr;
    logic [3:0]       r_s1_sb;
    logic [3:0]       r_sb [ROM_LAT];
    logic [3:0]       w_sb;

    assign w_col     = {1'b0, col_addr};
    assign w_row     = {1'b0, row_addr};
    assign w_fs      = pix_valid && (row_addr == 9'd0) && (col_addr == 10'd0);
    assign w_line    = pix_valid && (col_addr == 10'd0);
    assign w_in_cols = (w_col >= X0) && (w_col < X1);
    assign w_in_rows = (w_row >= Y0) && (w_row < Y1);
    assign w_in_grid = w_in_cols && w_in_rows;

    // w_* counters are the values belonging to the pixel currently on the scan address
    always_comb begin
        w_tx = r_tx;
        w_cx = r_cx;
        if (w_col == X0) begin
            w_tx = '0;
            w_cx = '0;
        end else if (w_in_cols) begin
            if (r_tx == T_MAX) begin
                w_tx = '0;
                w_cx = r_cx + 1'b1;
            end else begin
                w_tx = r_tx + 1'b1;
            end
        end
    end

    always_comb begin
        w_ty = r_ty;
        w_cy = r_cy;
        if (w_line) begin
            if (w_row == Y0) begin
                w_ty = '0;
                w_cy = '0;
            end else if ((w_row > Y0) && (w_row < Y1)) begin
                if (r_ty == T_MAX) begin
                    w_ty = '0;
                    w_cy = r_cy + 1'b1;
                end else begin
                    w_ty = r_ty + 1'b1;
                end
            end
        end
    end

    // The FS pixel already sees the freshly latched maps and the new blink phase
    assign w_cells    = w_fs ? cell_matrix : r_cell_sh;
    assign w_flashes  = w_fs ? flash_mask  : r_flash_sh;
    assign w_wrap     = w_fs && r_fs_seen && (r_fcnt == FC_MAX);
    assign w_phase    = r_phase ^ w_wrap;
    assign w_idx      = CI_W'(int'(w_cy) * GRID_COLS + int'(w_cx));
    assign w_cell_bit = w_in_grid && w_cells[w_idx];
    assign w_lit      = w_in_grid && w_flashes[w_idx] && w_phase;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_tx       <= '0;
            r_cx       <= '0;
            r_ty       <= '0;
            r_cy       <= '0;
            r_cell_sh  <= '0;
            r_flash_sh <= '0;
            r_fcnt     <= '0;
            r_fs_seen  <= 1'b0;
            r_phase    <= 1'b0;
        end else begin
            r_ty <= w_ty;
            r_cy <= w_cy;
            if (pix_valid) begin
                r_tx <= w_tx;
                r_cx <= w_cx;
            end
            if (w_fs) begin
                r_cell_sh  <= cell_matrix;
                r_flash_sh <= flash_mask;
                r_phase    <= w_phase;
                // the first frame after reset is frame 0 of the blink count
                if (!r_fs_seen)
                    r_fs_seen <= 1'b1;
                else if (r_fcnt == FC_MAX)
                    r_fcnt <= '0;
                else
                    r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_bg_addr   <= '0;
            r_tile_addr <= '0;
            r_s1_sb     <= '0;
            for (int i = 0; i < ROM_LAT; i++) r_sb[i] <= '0;
            pix_out       <= '0;
            pix_valid_out <= 1'b0;
        end else begin
            r_bg_addr   <= 19'(int'(row_addr) * H_ACTIVE + int'(col_addr));
            r_tile_addr <= w_in_grid ? TA_W'(int'(w_ty) * TILE + int'(w_tx)) : '0;
            r_s1_sb     <= {pix_valid, w_in_grid, w_cell_bit, w_lit};
            r_sb[0]     <= r_s1_sb;
            for (int i = 1; i < ROM_LAT; i++) r_sb[i] <= r_sb[i-1];
            pix_valid_out <= w_sb[3];
            if (!w_sb[3])
                pix_out <= 12'h000;
            else if (!w_sb[2])
                pix_out <= rom.bg_data;
            else if (w_sb[0])
                pix_out <= FLASH_COLOR;
            else if (w_sb[1])
                pix_out <= rom.tile_data;
            else
                pix_out <= rom.bg_data;
        end
    end

    assign w_sb          = r_sb[ROM_LAT-1];
    assign rom.bg_addr   = r_bg_addr;
    assign rom.tile_addr = r_tile_addr;
endmodule

// File: tb/tb_tile_grid_renderer.sv
// Directed bench: default-geometry renderer (A) plus a small 4x2 grid with
// ROM_LAT=2 and FLASH_FRAMES=2 (B), both fed from one sparse scan generator.
module tb_tile_grid_renderer;
    typedef logic [127:0] tag_t;
    typedef struct packed {
        logic        ca;
        logic [11:0] ea;
        logic        cb;
        logic [11:0] eb;
        logic        v;
        tag_t        tag;
    } ent_t;

    logic         clk = 1'b0;
    logic         clrn = 1'b0;
    logic         pv;
    logic [8:0]   row;
    logic [9:0]   col;
    logic [199:0] cm_a, fm_a;
    logic [7:0]   cm_b, fm_b;
    logic [11:0]  pix_a, pix_b;
    logic         pvo_a, pvo_b;
    logic [11:0]  b1_bg, b1_tile;

    int   n_checks = 0;
    int   n_err    = 0;
    ent_t cur;
    ent_t dl [4];

    always #20 clk = ~clk;

    tile_grid_renderer_if #(.TA_W(8)) u_if_a ();
    tile_grid_renderer_if #(.TA_W(6)) u_if_b ();

    tile_grid_renderer u_dut_a (
        .clk(clk), .clrn(clrn), .pix_valid(pv), .row_addr(row), .col_addr(col),
        .cell_matrix(cm_a), .flash_mask(fm_a), .rom(u_if_a.master),
        .pix_out(pix_a), .pix_valid_out(pvo_a)
    );

    tile_grid_renderer #(
        .GRID_COLS(4), .GRID_ROWS(2), .TILE(8), .ORIGIN_X(368), .ORIGIN_Y(279),
        .ROM_LAT(2), .FLASH_FRAMES(2)
    ) u_dut_b (
        .clk(clk), .clrn(clrn), .pix_valid(pv), .row_addr(row), .col_addr(col),
        .cell_matrix(cm_b), .flash_mask(fm_b), .rom(u_if_b.master),
        .pix_out(pix_b), .pix_valid_out(pvo_b)
    );

    function automatic logic [11:0] bgf(input logic [18:0] a);
        return a[11:0] ^ 12'h0F0;
    endfunction

    function automatic logic [11:0] bgx(input int r, input int c);
        return bgf(19'(r * 640 + c));
    endfunction

    // ROM models: background = f(address), tile = 0xA00 | address
    always @(posedge clk) begin
        u_if_a.bg_data   <= bgf(u_if_a.bg_addr);
        u_if_a.tile_data <= 12'hA00 | 12'(u_if_a.tile_addr);
        b1_bg            <= bgf(u_if_b.bg_addr);
        b1_tile          <= 12'hA00 | 12'(u_if_b.tile_addr);
        u_if_b.bg_data   <= b1_bg;
        u_if_b.tile_data <= b1_tile;
    end

    task automatic check(input tag_t tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        dl[0] <= cur;
        for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
    end

    // A output appears 3 cycles after its scan address, B output 4 cycles after
    always @(negedge clk) begin
        if (clrn) begin
            if (dl[2].ca) begin
                check(dl[2].tag, 32'(pix_a), 32'(dl[2].ea));
                check(dl[2].tag, 32'(pvo_a), 32'(dl[2].v));
            end
            if (dl[3].cb) begin
                check(dl[3].tag, 32'(pix_b), 32'(dl[3].eb));
                check(dl[3].tag, 32'(pvo_b), 32'(dl[3].v));
            end
        end
    end

    task automatic px(input int r, input int c, input logic v, input logic ca,
                      input logic [11:0] ea, input logic cb, input logic [11:0] eb,
                      input tag_t tag);
        @(posedge clk);
        #1;
        pv  = v;
        row = 9'(r);
        col = 10'(c);
        cur = '{ca: ca, ea: ea, cb: cb, eb: eb, v: v, tag: tag};
    endtask

    task automatic pn(input int r, input int c);
        px(r, c, 1'b1, 1'b0, 12'h0, 1'b0, 12'h0, "");
    endtask

    task automatic pa(input int r, input int c, input logic [11:0] e, input tag_t tag);
        px(r, c, 1'b1, 1'b1, e, 1'b0, 12'h0, tag);
    endtask

    task automatic pb(input int r, input int c, input logic [11:0] e, input tag_t tag);
        px(r, c, 1'b1, 1'b0, 12'h0, 1'b1, e, tag);
    endtask

    task automatic rows0(input int r0, input int r1);
        for (int r = r0; r <= r1; r++) pn(r, 0);
    endtask

    task automatic span(input int r, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) pn(r, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(0, 0, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0, "");
    endtask

    task automatic chk_rst_outs(input tag_t tag);
        check(tag, 32'(pix_a), 32'h0);
        check(tag, 32'(pvo_a), 32'h0);
        check(tag, 32'(u_if_a.bg_addr), 32'h0);
        check(tag, 32'(u_if_a.tile_addr), 32'h0);
        check(tag, 32'(pix_b), 32'h0);
        check(tag, 32'(pvo_b), 32'h0);
    endtask

    initial begin
        pv = 1'b0; row = '0; col = '0;
        cm_a = '0; fm_a = '0; cm_b = '0; fm_b = '0;
        cur = '0;
        #100 clrn = 1'b1;

        // random activity, then reset asserted mid-frame
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            pv  = 1'($urandom_range(0, 1));
            row = 9'($urandom_range(0, 479));
            col = 10'($urandom_range(0, 639));
            for (int k = 0; k < 200; k++) begin
                cm_a[k] = 1'($urandom_range(0, 1));
                fm_a[k] = 1'($urandom_range(0, 1));
            end
            cm_b = 8'($urandom);
            fm_b = 8'($urandom);
        end
        @(posedge clk); #5;
        clrn = 1'b0;
        #1 chk_rst_outs("rst_async");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            pv  = 1'($urandom_range(0, 1));
            row = 9'($urandom_range(0, 479));
            col = 10'($urandom_range(0, 639));
        end
        @(negedge clk);
        chk_rst_outs("rst_held");
        cm_a = '0; fm_a = '0; cm_b = '0; fm_b = '0;
        pv = 1'b0;
        @(negedge clk) clrn = 1'b1;

        // background-only frame
        px(0, 0, 1'b1, 1'b1, bgx(0, 0), 1'b1, bgx(0, 0), "fs_bg");
        rows0(1, 104);
        px(105, 0, 1'b1, 1'b1, bgx(105, 0), 1'b1, bgx(105, 0), "bg_col0");
        for (int c = 208; c <= 221; c++)
            px(105, c, 1'b1, 1'b1, bgx(105, c), 1'b1, bgx(105, c), "bg_grid");

        // cells 0 and 1: tile boundaries
        cm_a = 200'h3;
        pn(0, 0);
        rows0(1, 103);
        pn(104, 0);
        pa(104, 208, bgx(104, 208), "above_grid");
        pn(105, 0);
        pa(105, 207, bgx(105, 207), "left_of_grid");
        pa(105, 208, 12'hA00, "tile_origin");
        span(105, 209, 220);
        pa(105, 221, 12'hA0D, "tile_tx13");
        pa(105, 222, 12'hA00, "cell1_origin");
        rows0(106, 117);
        pn(118, 0);
        span(118, 208, 220);
        pa(118, 221, 12'hAC3, "tile_195");

        // far corner, only cell 199
        cm_a = '0;
        cm_a[199] = 1'b1;
        pn(0, 0);
        rows0(1, 383);
        pn(384, 0);
        span(384, 208, 346);
        pa(384, 347, 12'hAC3, "corner_195");
        pa(384, 348, bgx(384, 348), "corner_right");
        pn(385, 0);
        span(385, 208, 346);
        pa(385, 347, bgx(385, 347), "corner_below");

        // tear-free: map changed at row 200 only shows after the next FS
        cm_a = '0;
        cm_a[0] = 1'b1;
        pn(0, 0);
        rows0(1, 199);
        cm_a = '0;
        cm_a[60] = 1'b1;
        pn(200, 0);
        pa(200, 208, bgx(200, 208), "tear_hold");
        pn(0, 0);
        rows0(1, 104);
        pn(105, 0);
        pa(105, 208, bgx(105, 208), "tear_cleared");
        rows0(106, 199);
        pn(200, 0);
        pa(200, 208, 12'hA9A, "tear_new");

        // small grid: blink, wrap at 63, valid gaps; restart blink count from reset
        idle(6);
        cm_a = '0;
        clrn = 1'b0;
        idle(2);
        clrn = 1'b1;
        cm_b = 8'b0010_0001;
        fm_b = 8'b0010_0000;
        for (int f = 0; f < 6; f++) begin
            pn(0, 0);
            rows0(1, 285);
            pn(286, 0);
            span(286, 368, 374);
            pb(286, 375, 12'hA3F, "b_cell0");
            rows0(287, 293);
            pn(294, 0);
            span(294, 368, 379);
            px(0, 0, 1'b0, 1'b0, 12'h0, 1'b1, 12'h000, "b_gap");
            px(0, 0, 1'b0, 1'b0, 12'h0, 1'b1, 12'h000, "b_gap");
            span(294, 380, 382);
            pb(294, 383, (f == 2 || f == 3) ? 12'hCCC : 12'hA3F, "b_blink");
            pb(294, 384, bgx(294, 384), "b_right");
        end

        idle(8);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
